// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams instruction words into IMEM while holding
// the core in reset, then releases it to run the fresh image.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           sum_q, sum_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            count_d = '0;
            sum_d   = '0;
            len_d   = len;
            state_d = (len == '0) ? FLUSH : LOAD;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + count_q[ADDR_WIDTH-1:0];
          wdata_d = s_data;
          sum_d   = sum_q + s_data;
          count_d = count_q + ONE;
          if (count_q == len_q - ONE) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // last word is written this cycle; core starts next cycle
        state_d = RUN;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  assign s_ready    = (state_q == LOAD);
  assign core_rst_n = (state_q == RUN);
  assign busy       = (state_q == LOAD) || (state_q == FLUSH);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized loads against an image/checksum model,
// two instances (base 0 and base 1022) sharing the same stimulus.
module tb_imem_boot_loader;

  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [AW:0] len = '0;
  logic [31:0] s_data = '0;

  logic s_ready0, imem_we0, core_rst_n0, busy0, done0, err0;
  logic [AW-1:0] imem_addr0;
  logic [31:0] imem_wdata0, checksum0;
  logic s_ready1, imem_we1, core_rst_n1, busy1, done1, err1;
  logic [AW-1:0] imem_addr1;
  logic [31:0] imem_wdata1, checksum1;

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(10'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .core_rst_n(core_rst_n0),
    .busy(busy0), .done(done0), .err(err0), .checksum(checksum0)
  );

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(10'd1022)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .core_rst_n(core_rst_n1),
    .busy(busy1), .done(done1), .err(err1), .checksum(checksum1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa0[$], wc0[$], wa1[$];
  logic [31:0] wd0[$], wd1[$];
  int rdy_cnt, done_cnt, done_cyc;
  logic done_rst;

  always @(negedge clk) begin
    if (imem_we0) begin
      wa0.push_back(int'(imem_addr0));
      wd0.push_back(imem_wdata0);
      wc0.push_back(cyc);
    end
    if (imem_we1) begin
      wa1.push_back(int'(imem_addr1));
      wd1.push_back(imem_wdata1);
    end
    if (s_ready0) rdy_cnt++;
    if (done0) begin
      done_cnt++;
      done_cyc = cyc;
      done_rst = core_rst_n0;
    end
  end

  logic [31:0] exp_w[$];
  logic [31:0] exp_sum;
  int t0;

  task automatic clear_mon();
    wa0.delete(); wd0.delete(); wc0.delete();
    wa1.delete(); wd1.delete();
    rdy_cnt = 0; done_cnt = 0; done_cyc = -1; done_rst = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1,0,..., 2: random valid
  task automatic run_load(input int mode);
    int n, i, guard;
    n = exp_w.size();
    exp_sum = 0;
    foreach (exp_w[k]) exp_sum = exp_sum + exp_w[k];
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    len = n[AW:0];
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    guard = 0;
    while (i < n && guard < 4 * n + 50) begin
      case (mode)
        0: s_valid = 1'b1;
        1: s_valid = (guard % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = exp_w[i];
      @(negedge clk);
      if (s_valid && s_ready0) i++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    checks++;
    if (i !== n) begin
      errors++;
      $display("FAIL stream_timeout accepted=%0d want=%0d", i, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready0, imem_we0, core_rst_n0, busy0, done0, err0} !== 6'b0
        || imem_addr0 !== '0 || imem_wdata0 !== '0
        || checksum0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b we=%b crst=%b busy=%b done=%b err=%b addr=%0d wd=%h cs=%h want all 0",
               s_ready0, imem_we0, core_rst_n0, busy0, done0, err0,
               imem_addr0, imem_wdata0, checksum0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_err();
    @(posedge clk); #1;
    start = 1'b1;
    len = 11'd1025;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b want=1", err0);
    end
    checks++;
    if ({busy0, s_ready0, core_rst_n0} !== 3'b000) begin
      errors++;
      $display("FAIL err_idle busy/rdy/crst got=%b want=000",
               {busy0, s_ready0, core_rst_n0});
    end
    exp_w.delete();
    exp_w.push_back($urandom);
    exp_w.push_back($urandom);
    run_load(0);
    checks++;
    if (wa0.size() !== 2 || done_cnt !== 1 || core_rst_n0 !== 1'b1) begin
      errors++;
      $display("FAIL err_then_load writes=%0d done=%0d crst=%b want 2 1 1",
               wa0.size(), done_cnt, core_rst_n0);
    end
    checks++;
    if (err0 !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b want=1", err0);
    end
  endtask

  task automatic test_back_to_back();
    exp_w = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h0000006F};
    run_load(0);
    checks++;
    if (wa0.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", wa0.size());
    end
    for (int i = 0; i < 4 && i < wa0.size(); i++) begin
      checks++;
      if (wa0[i] !== i || wd0[i] !== exp_w[i] || wc0[i] !== t0 + 2 + i) begin
        errors++;
        $display("FAIL b2b_write%0d addr=%0d data=%h cyc=%0d want %0d %h %0d",
                 i, wa0[i], wd0[i], wc0[i], i, exp_w[i], t0 + 2 + i);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== t0 + 6 || done_rst !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done cnt=%0d cyc=%0d crst=%b want 1 %0d 1",
               done_cnt, done_cyc, done_rst, t0 + 6);
    end
    checks++;
    if (checksum0 !== exp_sum) begin
      errors++;
      $display("FAIL b2b_checksum got=%h want=%h", checksum0, exp_sum);
    end
  endtask

  task automatic test_toggle();
    exp_w = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h0000006F};
    run_load(1);
    checks++;
    if (wa0.size() !== 4) begin
      errors++;
      $display("FAIL toggle_pulses got=%0d want=4", wa0.size());
    end
    for (int i = 0; i < 4 && i < wa0.size(); i++) begin
      checks++;
      if (wa0[i] !== i || wd0[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL toggle_write%0d addr=%0d data=%h want %0d %h",
                 i, wa0[i], wd0[i], i, exp_w[i]);
      end
    end
    checks++;
    if (checksum0 !== exp_sum || core_rst_n0 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_end cs=%h crst=%b want %h 1",
               checksum0, core_rst_n0, exp_sum);
    end
  endtask

  task automatic test_wrap();
    exp_w.delete();
    for (int i = 0; i < 4; i++) exp_w.push_back($urandom);
    run_load(2);
    checks++;
    if (wa1.size() !== 4) begin
      errors++;
      $display("FAIL wrap_count got=%0d want=4", wa1.size());
    end
    for (int i = 0; i < 4 && i < wa1.size(); i++) begin
      checks++;
      if (wa1[i] !== (1022 + i) % DEPTH || wd1[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_write%0d addr=%0d data=%h want %0d %h",
                 i, wa1[i], wd1[i], (1022 + i) % DEPTH, exp_w[i]);
      end
    end
    checks++;
    if (core_rst_n1 !== 1'b1 || checksum1 !== exp_sum) begin
      errors++;
      $display("FAIL wrap_run crst=%b cs=%h want 1 %h",
               core_rst_n1, checksum1, exp_sum);
    end
  endtask

  task automatic test_len0();
    exp_w.delete();
    run_load(0);
    checks++;
    if (wa0.size() !== 0 || rdy_cnt !== 0) begin
      errors++;
      $display("FAIL len0_quiet writes=%0d ready_cycles=%0d want 0 0",
               wa0.size(), rdy_cnt);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== t0 + 2 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL len0_done cnt=%0d cyc=%0d now=%b want 1 %0d 0",
               done_cnt, done_cyc, done0, t0 + 2);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 9);
      exp_w.delete();
      for (int i = 0; i < n; i++) exp_w.push_back($urandom);
      run_load(2);
      checks++;
      if (wa0.size() !== n || wa1.size() !== n) begin
        errors++;
        $display("FAIL rand%0d_count got=%0d/%0d want=%0d",
                 r, wa0.size(), wa1.size(), n);
      end
      for (int i = 0; i < n && i < wa0.size() && i < wa1.size(); i++) begin
        checks++;
        if (wa0[i] !== i || wd0[i] !== exp_w[i]
            || wa1[i] !== (1022 + i) % DEPTH) begin
          errors++;
          $display("FAIL rand%0d_write%0d addr=%0d/%0d data=%h want %0d/%0d %h",
                   r, i, wa0[i], wa1[i], wd0[i], i, (1022 + i) % DEPTH,
                   exp_w[i]);
        end
      end
      checks++;
      if (checksum0 !== exp_sum || done_cnt !== 1 || core_rst_n0 !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_end cs=%h done=%0d crst=%b want %h 1 1",
                 r, checksum0, done_cnt, core_rst_n0, exp_sum);
      end
    end
  endtask

  task automatic test_full();
    exp_w.delete();
    for (int i = 0; i < DEPTH; i++) exp_w.push_back($urandom);
    run_load(0);
    checks++;
    if (wa1.size() !== DEPTH || err0 !== 1'b1) begin
      errors++;
      $display("FAIL full_count got=%0d err=%b want %0d 1",
               wa1.size(), err0, DEPTH);
    end
    for (int i = 0; i < DEPTH && i < wa1.size(); i++) begin
      checks++;
      if (wa1[i] !== (1022 + i) % DEPTH || wd1[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL full_write%0d addr=%0d data=%h want %0d %h",
                 i, wa1[i], wd1[i], (1022 + i) % DEPTH, exp_w[i]);
      end
    end
    checks++;
    if (checksum1 !== exp_sum || done_cyc !== t0 + DEPTH + 2) begin
      errors++;
      $display("FAIL full_end cs=%h done_cyc=%0d want %h %0d",
               checksum1, done_cyc, exp_sum, t0 + DEPTH + 2);
    end
  endtask

  task automatic test_restart_reset();
    logic [31:0] w;
    w = $urandom;
    @(posedge clk); #1;
    start = 1'b1;
    len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    @(negedge clk);
    checks++;
    if (core_rst_n0 !== 1'b0 || checksum0 !== 32'h0 || s_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_enter crst=%b cs=%h rdy=%b want 0 0 1",
               core_rst_n0, checksum0, s_ready0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_we0 !== 1'b1 || imem_addr0 !== '0 || imem_wdata0 !== w
        || checksum0 !== w) begin
      errors++;
      $display("FAIL restart_word we=%b addr=%0d data=%h cs=%h want 1 0 %h %h",
               imem_we0, imem_addr0, imem_wdata0, checksum0, w, w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready0, imem_we0, core_rst_n0, busy0, done0, err0} !== 6'b0
        || imem_addr0 !== '0 || imem_wdata0 !== '0
        || checksum0 !== '0) begin
      errors++;
      $display("FAIL async_reset rdy=%b we=%b crst=%b busy=%b done=%b err=%b addr=%0d wd=%h cs=%h want all 0",
               s_ready0, imem_we0, core_rst_n0, busy0, done0, err0,
               imem_addr0, imem_wdata0, checksum0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || core_rst_n0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b crst=%b want 0 0",
               busy0, core_rst_n0);
    end
  endtask

  initial begin
    test_reset();
    test_err();
    test_back_to_back();
    test_toggle();
    test_wrap();
    test_len0();
    test_random();
    test_full();
    test_restart_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the single-cycle RISC-V core. It holds the core in reset, accepts a stream of 32-bit instruction words over a valid/ready handshake, and writes them into consecutive instruction-memory word locations. It then releases the core so it begins fetching from the freshly loaded image. It sits between the external loader link (UART/JTAG/testbench) and the instruction memory write port, and drives the core's reset.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width (depth = 2^ADDR_WIDTH words)
- BASE_ADDR, 0, first word address written (ADDR_WIDTH bits)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  level-sampled request to begin a load
- len  input  ADDR_WIDTH+1  number of words to load; sampled on accepted start
- s_valid  input  1  stream word valid
- s_data  input  32  stream word
- s_ready  output  1  block can accept a stream word
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_WIDTH  instruction-memory word address
- imem_wdata  output  32  instruction-memory write data
- core_rst_n  output  1  active-low reset to the core (PC, register file)
- busy  output  1  high in LOAD or FLUSH
- done  output  1  one-cycle pulse on entering RUN
- err  output  1  sticky: a start was rejected because len > 2^ADDR_WIDTH
- checksum  output  32  sum mod 2^32 of the words accepted in the current or last load

## Operation
- FSM states: IDLE, LOAD, FLUSH, RUN. All outputs are registered or decoded from state only. No output depends combinationally on s_valid or start.
- IDLE: core_rst_n=0, s_ready=0. When start=1:
  - If len > 2^ADDR_WIDTH: set err, stay IDLE.
  - If len == 0: go to FLUSH. No write occurs.
  - Otherwise: latch len, clear count and checksum, go to LOAD.
- LOAD: s_ready=1, core_rst_n=0. Each cycle with s_valid&s_ready is a handshake:
  - Capture s_data.
  - Add s_data to checksum.
  - Increment count.
  - On the handshake where count == len-1, go to FLUSH.
  - start is ignored in LOAD.
- FLUSH: s_ready=0, core_rst_n=0. This state lasts exactly one cycle, then the block goes to RUN.
- RUN: core_rst_n=1, s_ready=0. done pulses in the first RUN cycle. start=1 in RUN:
  - Invalid len: set err, stay in RUN.
  - Valid len: restart exactly as from IDLE. core_rst_n drops in the next cycle.
- Addressing:
  - imem_addr = (BASE_ADDR + index) mod 2^ADDR_WIDTH, where index is the 0-based word index.
  - The address wraps silently at the top of memory.
  - len == 2^ADDR_WIDTH fills the whole memory.
- err is cleared only by rst_n.
- checksum holds its value after load until the next accepted start.

## Timing
- Reset (asynchronous, immediate on rst_n=0) drives every output and internal register to:
  - state=IDLE, core_rst_n=0, s_ready=0, imem_we=0
  - imem_addr=0, imem_wdata=0, count=0
  - busy=0, done=0, err=0, checksum=0
- Reset mid-load abandons the load. Words already written stay in memory.
- The write port is registered with 1-cycle latency. For a handshake in cycle t, the block drives imem_we=1, imem_addr and imem_wdata in cycle t+1. imem_we=0 otherwise.
- The last word's write occurs in the FLUSH cycle. core_rst_n rises one cycle after FLUSH, so the memory is complete before the first fetch.
- The start→s_ready latency is 1 cycle: start accepted in cycle t gives LOAD (s_ready=1) in t+1.
- Throughput is one word per cycle while s_valid stays high. For a len-word load starting at t, core_rst_n rises at t+len+2 at the earliest.
- s_ready drops in the cycle after the final handshake. The source must hold s_data stable while s_valid=1 && s_ready=0.
- checksum reflects all handshakes up to the previous clock edge.

## Test plan
- Reset, then start with len=4 and words 0x00500093, 0x00300113, 0x002081B3, 0x0000006F streamed back-to-back. Required response:
  - Writes to addr 0..3 in cycles t+2..t+5.
  - done and core_rst_n=1 at t+6.
  - checksum = sum mod 2^32.
- Same load with s_valid toggling 1,0,1,0: writes occur only after handshakes. The address sequence is 0,1,2,3 with no duplicates. There are exactly 4 imem_we pulses.
- BASE_ADDR=1022, ADDR_WIDTH=10, len=4: addresses 1022, 1023, 0, 1. Then RUN.
- len=0: no imem_we, s_ready never high, done pulses 2 cycles after start.
- len=1025 with ADDR_WIDTH=10: err=1, state stays IDLE, core_rst_n stays 0. A following valid start (len=2) still completes and err remains 1.
- In RUN, start with len=2: core_rst_n=0 next cycle and checksum cleared. Assert rst_n=0 after the first word: all outputs return to reset values immediately, without waiting for a clock edge.
